// File: rtl/aes_inv_key_unroll.sv
// Inverse AES-128 key schedule: takes the round-10 key and emits round keys 10..0,
// one per valid/ready handshake, deriving each previous key on the fly.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 via an addition chain; maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign o_byte = sbox_calc(i_byte);

endmodule

module aes_inv_key_unroll #(
  parameter int         NR        = 10,
  parameter int         IDX_W     = 4,
  parameter logic [7:0] RCON_LAST = 8'h36
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [127:0]     i_last_key,
  output logic             o_key_valid,
  input  logic             i_key_ready,
  output logic [127:0]     o_round_key,
  output logic [IDX_W-1:0] o_round_idx,
  output logic             o_key_last
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           r_state;
  logic             r_start_ready;
  logic             r_key_valid;
  logic             r_key_last;
  logic [127:0]     r_round_key;
  logic [IDX_W-1:0] r_round_idx;
  logic [7:0]       r_rcon;

  state_t           w_state_next;
  logic             w_start_ready_next;
  logic             w_key_valid_next;
  logic             w_key_last_next;
  logic [127:0]     w_round_key_next;
  logic [IDX_W-1:0] w_round_idx_next;
  logic [7:0]       w_rcon_next;

  logic [31:0]      w_w0, w_w1, w_w2, w_w3;
  logic [31:0]      w_p0, w_p1, w_p2, w_p3;
  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [7:0]       w_rcon_inv;

  assign w_w0 = r_round_key[127:96];
  assign w_w1 = r_round_key[95:64];
  assign w_w2 = r_round_key[63:32];
  assign w_w3 = r_round_key[31:0];

  // Later words of the previous key fall out by XOR; p0 needs SubWord of the recovered p3.
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};
  assign w_p0  = w_w0 ^ w_sub ^ {r_rcon, 24'h000000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .i_byte (w_rot[8*gi +: 8]),
        .o_byte (w_sub[8*gi +: 8])
      );
    end
  endgenerate

  assign w_rcon_inv = r_rcon[0] ? ({1'b0, r_rcon[7:1]} ^ 8'h8d) : {1'b0, r_rcon[7:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_start_ready <= 1'b1;
      r_key_valid   <= 1'b0;
      r_key_last    <= 1'b0;
      r_round_key   <= '0;
      r_round_idx   <= '0;
      r_rcon        <= RCON_LAST;
    end else begin
      r_state       <= w_state_next;
      r_start_ready <= w_start_ready_next;
      r_key_valid   <= w_key_valid_next;
      r_key_last    <= w_key_last_next;
      r_round_key   <= w_round_key_next;
      r_round_idx   <= w_round_idx_next;
      r_rcon        <= w_rcon_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_start_ready_next = r_start_ready;
    w_key_valid_next   = r_key_valid;
    w_key_last_next    = r_key_last;
    w_round_key_next   = r_round_key;
    w_round_idx_next   = r_round_idx;
    w_rcon_next        = r_rcon;
    case (r_state)
      S_IDLE: begin
        if (i_start_valid) begin
          w_state_next       = S_EMIT;
          w_start_ready_next = 1'b0;
          w_key_valid_next   = 1'b1;
          w_key_last_next    = (NR == 0);
          w_round_key_next   = i_last_key;
          w_round_idx_next   = IDX_W'(NR);
          w_rcon_next        = RCON_LAST;
        end
      end
      S_EMIT: begin
        if (i_key_ready) begin
          if (r_round_idx != '0) begin
            w_round_key_next = {w_p0, w_p1, w_p2, w_p3};
            w_round_idx_next = r_round_idx - IDX_W'(1);
            w_rcon_next      = w_rcon_inv;
            w_key_last_next  = (r_round_idx == IDX_W'(1));
          end else begin
            w_state_next       = S_IDLE;
            w_start_ready_next = 1'b1;
            w_key_valid_next   = 1'b0;
            w_key_last_next    = 1'b0;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_start_ready = r_start_ready;
  assign o_key_valid   = r_key_valid;
  assign o_key_last    = r_key_last;
  assign o_round_key   = r_round_key;
  assign o_round_idx   = r_round_idx;

endmodule

// File: tb/tb_aes_inv_key_unroll.sv
// Directed and randomised bench for aes_inv_key_unroll: FIPS-197 A.1 walk, backpressure,
// ignored starts, mid-walk reset and forward-expansion cross-check.

module tb_aes_inv_key_unroll;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [127:0] last_key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_last;

  int checks;
  int errors;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_key [0:10];
  logic [3:0]   got_idx [0:10];
  logic         got_last [0:10];
  int           got_n;

  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;

  aes_inv_key_unroll #(.NR(10), .IDX_W(4), .RCON_LAST(8'h36)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_valid (start_valid),
    .o_start_ready (start_ready),
    .i_last_key    (last_key),
    .o_key_valid   (key_valid),
    .i_key_ready   (key_ready),
    .o_round_key   (round_key),
    .o_round_idx   (round_idx),
    .o_key_last    (key_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from log/antilog tables over generator 3, then the affine map.
  task automatic build_sbox();
    logic [7:0] exp_t [0:255];
    int         log_t [0:255];
    logic [7:0] e;
    logic [7:0] inv;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
          ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [127:0] k);
    start_valid = 1'b1;
    last_key    = k;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Records keys with key_ready held high, starting at the current negedge.
  task automatic collect();
    int cyc;
    got_n = 0;
    cyc   = 0;
    key_ready = 1'b1;
    while (got_n < 11 && cyc < 200) begin
      if (key_valid) begin
        got_key[got_n]  = round_key;
        got_idx[got_n]  = round_idx;
        got_last[got_n] = key_last;
        got_n++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || key_valid !== 1'b0 || round_key !== 128'h0 ||
        round_idx !== 4'h0 || key_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b key=%h idx=%0d last=%b required rdy=1 vld=0 key=0 idx=0 last=0",
               start_ready, key_valid, round_key, round_idx, key_last);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b required rdy=1 vld=0", start_ready, key_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_fips();
    int nlast;
    key_ready = 1'b1;
    do_start(A1_LAST);
    checks++;
    if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== A1_LAST || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL fips_first_key: vld=%b idx=%0d key=%h rdy=%b required vld=1 idx=10 key=%h rdy=0",
               key_valid, round_idx, round_key, start_ready, A1_LAST);
    end
    collect();
    checks++;
    if (got_n != 11) begin
      errors++;
      $display("FAIL fips_count: got %0d keys required 11", got_n);
    end else begin
      checks++;
      if (got_key[1] !== A1_R9) begin
        errors++;
        $display("FAIL fips_round9: got %h required %h", got_key[1], A1_R9);
      end
      checks++;
      if (got_key[9] !== A1_R1) begin
        errors++;
        $display("FAIL fips_round1: got %h required %h", got_key[9], A1_R1);
      end
      checks++;
      if (got_key[10] !== A1_KEY || got_last[10] !== 1'b1 || got_idx[10] !== 4'd0) begin
        errors++;
        $display("FAIL fips_round0: got %h last=%b idx=%0d required %h last=1 idx=0",
                 got_key[10], got_last[10], got_idx[10], A1_KEY);
      end
      nlast = 0;
      for (int i = 0; i < 10; i++) if (got_last[i] !== 1'b0) nlast++;
      checks++;
      if (nlast != 0) begin
        errors++;
        $display("FAIL fips_early_last: %0d keys before round 0 had key_last set, required 0", nlast);
      end
    end
    checks++;
    if (key_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL fips_back_to_idle: vld=%b rdy=%b required vld=0 rdy=1", key_valid, start_ready);
    end
    $display("test_fips done: %0d keys", got_n);
  endtask

  task automatic test_backpressure();
    logic         prev_stall;
    logic [127:0] pk;
    logic [3:0]   pi;
    logic         pl;
    int           cyc;
    int           nstall;
    expand(A1_KEY);
    key_ready = 1'b0;
    do_start(A1_LAST);
    got_n = 0;
    cyc = 0;
    nstall = 0;
    prev_stall = 1'b0;
    pk = '0; pi = '0; pl = 1'b0;
    while (got_n < 11 && cyc < 400) begin
      if (prev_stall) begin
        nstall++;
        checks++;
        if (key_valid !== 1'b1 || round_key !== pk || round_idx !== pi || key_last !== pl) begin
          errors++;
          $display("FAIL stall_stable: vld=%b key=%h idx=%0d last=%b required vld=1 key=%h idx=%0d last=%b",
                   key_valid, round_key, round_idx, key_last, pk, pi, pl);
        end
      end
      key_ready = 1'($urandom_range(0, 1));
      if (key_valid) begin
        if (key_ready) begin
          got_key[got_n] = round_key;
          got_idx[got_n] = round_idx;
          got_last[got_n] = key_last;
          got_n++;
        end
        prev_stall = !key_ready;
        pk = round_key; pi = round_idx; pl = key_last;
      end else begin
        prev_stall = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    key_ready = 1'b1;
    checks++;
    if (got_n != 11) begin
      errors++;
      $display("FAIL bp_count: got %0d keys required 11", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_key[i] !== exp_rk[10-i] || got_idx[i] !== 4'(10-i) || got_last[i] !== (i == 10)) begin
        errors++;
        $display("FAIL bp_key%0d: key=%h idx=%0d last=%b required key=%h idx=%0d last=%b",
                 i, got_key[i], got_idx[i], got_last[i], exp_rk[10-i], 10-i, (i == 10));
      end
    end
    $display("test_backpressure done: %0d keys, %0d stalled cycles", got_n, nstall);
  endtask

  task automatic test_start_during_emit();
    int           cyc;
    logic [127:0] k2;
    expand(A1_KEY);
    key_ready = 1'b1;
    do_start(A1_LAST);
    got_n = 0;
    cyc = 0;
    while (got_n < 11 && cyc < 200) begin
      checks++;
      if (start_ready !== 1'b0) begin
        errors++;
        $display("FAIL emit_start_ready: rdy=%b required 0 (cycle %0d)", start_ready, cyc);
      end
      start_valid = (cyc == 3 || cyc == 4 || cyc == 10);
      last_key    = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (key_valid) begin
        got_key[got_n] = round_key;
        got_idx[got_n] = round_idx;
        got_n++;
      end
      @(negedge clk);
      cyc++;
    end
    start_valid = 1'b0;
    checks++;
    if (got_n != 11) begin
      errors++;
      $display("FAIL ign_count: got %0d keys required 11", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_key[i] !== exp_rk[10-i] || got_idx[i] !== 4'(10-i)) begin
        errors++;
        $display("FAIL ign_key%0d: key=%h idx=%0d required key=%h idx=%0d",
                 i, got_key[i], got_idx[i], exp_rk[10-i], 10-i);
      end
    end
    // Back-to-back: start in the IDLE cycle right after the last handshake.
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(k2);
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_ready: rdy=%b required 1", start_ready);
    end
    do_start(exp_rk[10]);
    checks++;
    if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== exp_rk[10]) begin
      errors++;
      $display("FAIL b2b_first_key: vld=%b idx=%0d key=%h required vld=1 idx=10 key=%h",
               key_valid, round_idx, round_key, exp_rk[10]);
    end
    collect();
    checks++;
    if (got_n != 11 || got_key[10] !== k2 || got_last[10] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_walk: n=%0d key0=%h last=%b required n=11 key0=%h last=1",
               got_n, got_key[10], got_last[10], k2);
    end
    $display("test_start_during_emit done");
  endtask

  task automatic test_reset_midwalk();
    int           cyc;
    logic [127:0] k3;
    key_ready = 1'b1;
    do_start(A1_LAST);
    cyc = 0;
    while (!(key_valid && round_idx == 4'd5) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    key_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1 || round_idx !== 4'd5) begin
      errors++;
      $display("FAIL rst_mid_pre: vld=%b idx=%0d required vld=1 idx=5", key_valid, round_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (key_valid !== 1'b0 || round_key !== 128'h0 || round_idx !== 4'h0 || key_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: vld=%b key=%h idx=%0d last=%b required vld=0 key=0 idx=0 last=0",
               key_valid, round_key, round_idx, key_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: rdy=%b vld=%b required rdy=1 vld=0", start_ready, key_valid);
    end
    k3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(k3);
    do_start(exp_rk[10]);
    collect();
    checks++;
    if (got_n != 11) begin
      errors++;
      $display("FAIL rst_new_count: got %0d keys required 11", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_key[i] !== exp_rk[10-i]) begin
        errors++;
        $display("FAIL rst_new_key%0d: got %h required %h", i, got_key[i], exp_rk[10-i]);
      end
    end
    $display("test_reset_midwalk done");
  endtask

  task automatic test_random();
    logic [127:0] ck;
    int           bad;
    for (int n = 0; n < 1000; n++) begin
      ck = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(ck);
      do_start(exp_rk[10]);
      collect();
      checks++;
      if (got_n != 11) begin
        errors++;
        $display("FAIL rnd_count: key %0d got %0d round keys required 11", n, got_n);
      end
      bad = 0;
      for (int i = 0; i < got_n; i++) begin
        checks++;
        if (got_key[i] !== exp_rk[10-i] || got_idx[i] !== 4'(10-i) || got_last[i] !== (i == 10)) begin
          errors++;
          bad++;
          if (bad < 3)
            $display("FAIL rnd_key: walk %0d step %0d key=%h idx=%0d last=%b required key=%h idx=%0d last=%b",
                     n, i, got_key[i], got_idx[i], got_last[i], exp_rk[10-i], 10-i, (i == 10));
        end
      end
    end
    $display("test_random done: 1000 walks");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    start_valid = 1'b0;
    key_ready = 1'b0;
    last_key = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_start_during_emit();
    test_reset_midwalk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
